multi_cycle_ctrl: RTL and testbench

- Main control FSM for the planned multi-cycle MIPS datapath. It replaces the single-cycle Decoder/ALU_Ctrl-per-instruction scheme.
- Sequences one shared memory, one ALU, the IR/PC write enables and the write-back muxes across 3-5 states per instruction.
- Supports R-type, jr, lw, sw, beq, addi, j and jal. Adds a memory ready handshake and a retired-instruction counter.

---
 rtl/mc_ctrl_pkg.sv | 40 ++++
 rtl/multi_cycle_ctrl_outdec.sv | 99 +++++++++
 rtl/multi_cycle_ctrl.sv | 127 ++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state, opcode and control-field encodings for the multi-cycle MIPS control FSM
package mc_ctrl_pkg;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR = 4'd2;
  localparam logic [3:0] ST_MEM_RD   = 4'd3;
  localparam logic [3:0] ST_MEM_WB   = 4'd4;
  localparam logic [3:0] ST_MEM_WR   = 4'd5;
  localparam logic [3:0] ST_EXEC     = 4'd6;
  localparam logic [3:0] ST_R_WB     = 4'd7;
  localparam logic [3:0] ST_BRANCH   = 4'd8;
  localparam logic [3:0] ST_JUMP     = 4'd9;
  localparam logic [3:0] ST_ADDI_EX  = 4'd10;
  localparam logic [3:0] ST_ADDI_WB  = 4'd11;
  localparam logic [3:0] ST_JAL      = 4'd12;
  localparam logic [3:0] ST_JR       = 4'd13;
  localparam logic [3:0] ST_TRAP     = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_e;
  typedef enum logic [1:0] {RD_RT = 2'b00, RD_RD = 2'b01, RD_R31 = 2'b10} reg_dst_e;
  typedef enum logic [1:0] {M2R_ALUOUT = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b11} mem_to_reg_e;
  typedef enum logic [1:0] {SRCB_B = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH = 2'b11} alu_src_b_e;
  typedef enum logic [1:0] {PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10, PCS_AREG = 2'b11} pc_source_e;

  // States that sit on the shared memory and may stall on mem_ready.
  function automatic logic is_wait_state(input logic [3:0] st);
    return (st == ST_FETCH) || (st == ST_MEM_RD) || (st == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_outdec.sv
// rtl/multi_cycle_ctrl_outdec.sv - combinational state-to-control-vector decode
module multi_cycle_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = RD_RT;
    mem_to_reg    = M2R_ALUOUT;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCS_ALU;
    case (state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE:   alu_src_b = SRCB_IMM_SH;
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = RD_RD;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCS_JUMP;
      end
      ST_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_ADDI_WB: reg_write = 1'b1;
      // PC already holds PC+4 here, so mem_to_reg=PC links the return address.
      ST_JAL: begin
        pc_write   = 1'b1;
        pc_source  = PCS_JUMP;
        reg_write  = 1'b1;
        reg_dst    = RD_R31;
        mem_to_reg = M2R_PC;
      end
      ST_JR: begin
        pc_write  = 1'b1;
        pc_source = PCS_AREG;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle MIPS main control FSM with memory wait, timeout trap and retire counter
module multi_cycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic [1:0]       reg_dst_o,
  output logic [1:0]       mem_to_reg_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic [3:0]       state_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_o
);

  logic [3:0]       state;
  logic [3:0]       state_nxt;
  logic [31:0]      wait_cnt;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  logic             timeout;

  logic       d_pc_write, d_pc_write_cond, d_iord, d_mem_read, d_mem_write, d_ir_write;
  logic       d_reg_write, d_alu_src_a;
  logic [1:0] d_reg_dst, d_mem_to_reg, d_alu_src_b, d_alu_op, d_pc_source;

  // A completing access wins over an expiring timeout in the same cycle.
  assign timeout = (WAIT_MAX > 0) && is_wait_state(state) && !mem_ready_i
                   && (wait_cnt >= 32'(WAIT_MAX));

  always_comb begin
    state_nxt = ST_TRAP;
    case (state)
      ST_FETCH:    state_nxt = mem_ready_i ? ST_DECODE : (timeout ? ST_TRAP : ST_FETCH);
      ST_DECODE: begin
        case (opcode_i)
          OP_RTYPE:     state_nxt = (funct_i == FUNCT_JR) ? ST_JR : ST_EXEC;
          OP_LW, OP_SW: state_nxt = ST_MEM_ADDR;
          OP_BEQ:       state_nxt = ST_BRANCH;
          OP_ADDI:      state_nxt = ST_ADDI_EX;
          OP_J:         state_nxt = ST_JUMP;
          OP_JAL:       state_nxt = ST_JAL;
          default:      state_nxt = ST_TRAP;
        endcase
      end
      ST_MEM_ADDR: state_nxt = (opcode_i == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   state_nxt = mem_ready_i ? ST_MEM_WB : (timeout ? ST_TRAP : ST_MEM_RD);
      ST_MEM_WR:   state_nxt = mem_ready_i ? ST_FETCH : (timeout ? ST_TRAP : ST_MEM_WR);
      ST_EXEC:     state_nxt = ST_R_WB;
      ST_ADDI_EX:  state_nxt = ST_ADDI_WB;
      ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB, ST_JAL, ST_JR:
                   state_nxt = ST_FETCH;
      default:     state_nxt = ST_TRAP;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state <= state_nxt;
      if (is_wait_state(state) && !mem_ready_i && (state_nxt == state))
        wait_cnt <= wait_cnt + 32'd1;
      else
        wait_cnt <= '0;
      if (state_nxt == ST_TRAP)
        illegal_q <= 1'b1;
      if ((state_nxt == ST_FETCH) && (state != ST_FETCH))
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  multi_cycle_ctrl_outdec u_outdec (
    .state         (state),
    .mem_ready     (mem_ready_i),
    .pc_write      (d_pc_write),
    .pc_write_cond (d_pc_write_cond),
    .iord          (d_iord),
    .mem_read      (d_mem_read),
    .mem_write     (d_mem_write),
    .ir_write      (d_ir_write),
    .reg_dst       (d_reg_dst),
    .mem_to_reg    (d_mem_to_reg),
    .reg_write     (d_reg_write),
    .alu_src_a     (d_alu_src_a),
    .alu_src_b     (d_alu_src_b),
    .alu_op        (d_alu_op),
    .pc_source     (d_pc_source)
  );

  // Reset squashes every control immediately, so no write escapes on the reset edge.
  assign pc_write_o      = d_pc_write      & ~rst_i;
  assign pc_write_cond_o = d_pc_write_cond & ~rst_i;
  assign iord_o          = d_iord          & ~rst_i;
  assign mem_read_o      = d_mem_read      & ~rst_i;
  assign mem_write_o     = d_mem_write     & ~rst_i;
  assign ir_write_o      = d_ir_write      & ~rst_i;
  assign reg_write_o     = d_reg_write     & ~rst_i;
  assign alu_src_a_o     = d_alu_src_a     & ~rst_i;
  assign reg_dst_o       = d_reg_dst       & {2{~rst_i}};
  assign mem_to_reg_o    = d_mem_to_reg    & {2{~rst_i}};
  assign alu_src_b_o     = d_alu_src_b     & {2{~rst_i}};
  assign alu_op_o        = d_alu_op        & {2{~rst_i}};
  assign pc_source_o     = d_pc_source     & {2{~rst_i}};
  assign state_o         = state;
  assign illegal_o       = illegal_q;
  assign retired_o       = retired_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - self-checking bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, ready = 1'b1;
  logic [5:0] opcode = 6'h00, funct = 6'h00;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a, illegal;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [31:0] retired;

  logic       rst2 = 1'b1, ready2 = 1'b0;
  logic       pc_write2, pc_write_cond2, iord2, mem_read2, mem_write2, ir_write2, reg_write2, alu_src_a2, illegal2;
  logic [1:0] reg_dst2, mem_to_reg2, alu_src_b2, alu_op2, pc_source2;
  logic [3:0] state2;
  logic [31:0] retired2;

  multi_cycle_ctrl #(.CNT_W(32), .WAIT_MAX(0)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct_i(funct), .mem_ready_i(ready),
    .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .iord_o(iord), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .ir_write_o(ir_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
    .reg_write_o(reg_write), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
    .pc_source_o(pc_source), .state_o(state), .illegal_o(illegal), .retired_o(retired)
  );

  multi_cycle_ctrl #(.CNT_W(32), .WAIT_MAX(4)) dut_to (
    .clk_i(clk), .rst_i(rst2), .opcode_i(opcode), .funct_i(funct), .mem_ready_i(ready2),
    .pc_write_o(pc_write2), .pc_write_cond_o(pc_write_cond2), .iord_o(iord2), .mem_read_o(mem_read2),
    .mem_write_o(mem_write2), .ir_write_o(ir_write2), .reg_dst_o(reg_dst2), .mem_to_reg_o(mem_to_reg2),
    .reg_write_o(reg_write2), .alu_src_a_o(alu_src_a2), .alu_src_b_o(alu_src_b2), .alu_op_o(alu_op2),
    .pc_source_o(pc_source2), .state_o(state2), .illegal_o(illegal2), .retired_o(retired2)
  );

  logic [17:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                 reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  int          n_vec = 0, n_err = 0;
  logic [31:0] retired_m = 32'd0;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [2:0]  len;
    logic [19:0] path;   // expected state per cycle, first state in the top nibble
  } vec_t;
  vec_t vecs[8];

  // Control vector each state must show, straight from the state table.
  function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input logic rdy);
    logic pw = 0, pwc = 0, io = 0, mr = 0, mw = 0, irw = 0, rw = 0, sa = 0;
    logic [1:0] rd = 0, m2r = 0, sb = 0, aop = 0, ps = 0;
    case (st)
      4'd0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; io = 1; end
      4'd4:  begin rw = 1; m2r = 2'b01; end
      4'd5:  begin mw = 1; io = 1; end
      4'd6:  begin sa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 2'b01; end
      4'd8:  begin sa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      4'd9:  begin pw = 1; ps = 2'b10; end
      4'd10: begin sa = 1; sb = 2'b10; end
      4'd11: rw = 1;
      4'd12: begin pw = 1; ps = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b11; end
      4'd13: begin pw = 1; ps = 2'b11; end
      default: ;
    endcase
    return {pw, pwc, io, mr, mw, irw, rd, m2r, rw, sa, sb, aop, ps};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rdy, input logic rs);
    @(negedge clk);
    ready = rdy;
    rst   = rs;
    #1;
  endtask

  task automatic check_cycle(input logic [3:0] st, input logic rdy);
    chk("state", 32'(state), 32'(st));
    chk("ctrl", 32'(ctrl), 32'(exp_ctrl(st, rdy)));
    chk("retired", retired, retired_m);
    chk("illegal", 32'(illegal), 32'd0);
  endtask

  // Reference model: the instruction's state walk from the ISA rules, with memory stalls inserted.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm, input bit rnd);
    logic [3:0] path[$];
    int         nw;
    logic       r, is_wait;
    opcode = op;
    funct  = fn;
    path.push_back(4'd0);
    path.push_back(4'd1);
    case (op)
      6'h00: if (fn == 6'h08) path.push_back(4'd13);
             else begin path.push_back(4'd6); path.push_back(4'd7); end
      6'h23: begin path.push_back(4'd2); path.push_back(4'd3); path.push_back(4'd4); end
      6'h2B: begin path.push_back(4'd2); path.push_back(4'd5); end
      6'h04: path.push_back(4'd8);
      6'h08: begin path.push_back(4'd10); path.push_back(4'd11); end
      6'h02: path.push_back(4'd9);
      6'h03: path.push_back(4'd12);
      default: ;
    endcase
    foreach (path[i]) begin
      is_wait = (path[i] == 4'd0) || (path[i] == 4'd3) || (path[i] == 4'd5);
      nw = (path[i] == 4'd0) ? wf : (is_wait ? wm : 0);
      for (int w = 0; w < nw; w++) begin
        cycle(1'b0, 1'b0);
        check_cycle(path[i], 1'b0);
      end
      r = (is_wait || !rnd) ? 1'b1 : 1'($urandom_range(0, 1));
      cycle(r, 1'b0);
      check_cycle(path[i], r);
    end
    retired_m++;
  endtask

  logic [5:0] ops[7];
  logic [3:0] st;

  initial begin
    vecs[0] = '{op: 6'h00, fn: 6'h20, len: 3'd4, path: 20'h01670};
    vecs[1] = '{op: 6'h00, fn: 6'h08, len: 3'd3, path: 20'h01D00};
    vecs[2] = '{op: 6'h23, fn: 6'h00, len: 3'd5, path: 20'h01234};
    vecs[3] = '{op: 6'h2B, fn: 6'h00, len: 3'd4, path: 20'h01250};
    vecs[4] = '{op: 6'h04, fn: 6'h00, len: 3'd3, path: 20'h01800};
    vecs[5] = '{op: 6'h08, fn: 6'h00, len: 3'd4, path: 20'h01AB0};
    vecs[6] = '{op: 6'h02, fn: 6'h00, len: 3'd3, path: 20'h01900};
    vecs[7] = '{op: 6'h03, fn: 6'h00, len: 3'd3, path: 20'h01C00};
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h03};

    // Reset held for two cycles with memory ready: everything quiet.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1);
      chk("rst_ctrl", 32'(ctrl), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_retired", retired, 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
    end

    // Fixed per-instruction walks with zero memory wait.
    foreach (vecs[v]) begin
      opcode = vecs[v].op;
      funct  = vecs[v].fn;
      for (int i = 0; i < int'(vecs[v].len); i++) begin
        st = vecs[v].path[19 - 4*i -: 4];
        cycle(1'b1, 1'b0);
        check_cycle(st, 1'b1);
      end
      retired_m++;
    end

    // sw stalled three cycles in MEM_WR.
    run_instr(6'h2B, 6'h00, 0, 3, 1'b0);

    // Illegal opcode traps and stays trapped until reset.
    opcode = 6'h3F;
    cycle(1'b1, 1'b0); check_cycle(4'd0, 1'b1);
    cycle(1'b1, 1'b0); check_cycle(4'd1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'b0);
      chk("trap_state", 32'(state), 32'd14);
      chk("trap_illegal", 32'(illegal), 32'd1);
      chk("trap_ctrl", 32'(ctrl), 32'd0);
      chk("trap_retired", retired, retired_m);
    end
    cycle(1'b1, 1'b1);
    chk("trap_rst_ctrl", 32'(ctrl), 32'd0);
    retired_m = 32'd0;
    cycle(1'b0, 1'b0);
    chk("trap_clr_state", 32'(state), 32'd0);
    chk("trap_clr_illegal", 32'(illegal), 32'd0);
    chk("trap_clr_retired", retired, 32'd0);

    // Reset pulsed while lw is stalled in MEM_RD.
    opcode = 6'h23;
    cycle(1'b1, 1'b0); check_cycle(4'd0, 1'b1);
    cycle(1'b1, 1'b0); check_cycle(4'd1, 1'b1);
    cycle(1'b1, 1'b0); check_cycle(4'd2, 1'b1);
    cycle(1'b0, 1'b0); check_cycle(4'd3, 1'b0);
    cycle(1'b0, 1'b1);
    chk("midrd_rst_ctrl", 32'(ctrl), 32'd0);
    cycle(1'b0, 1'b0);
    chk("midrd_state", 32'(state), 32'd0);
    chk("midrd_retired", retired, 32'd0);

    // Randomized instruction mix with random memory stalls.
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
      run_instr(op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
    end

    // WAIT_MAX=4 instance: FETCH starved of ready traps on the fifth cycle after entry.
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      rst2   = 1'b0;
      ready2 = 1'b0;
      #1;
      chk("to_state", 32'(state2), (i < 5) ? 32'd0 : 32'd14);
      chk("to_illegal", 32'(illegal2), (i < 5) ? 32'd0 : 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
